// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: drains a byte FIFO and serializes each byte as an
// asynchronous 1-start / DATA_W-data / 1-stop frame, LSB first.
// Every output is a register; the FSM updates state and outputs together.
module fifo_serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_is_empty,
  output logic              fifo_r,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // byte_done is registered, so it is set one cycle before the last stop cycle
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   shift_q;
  logic [BIT_W-1:0]    bit_q;
  logic [BAUD_W-1:0]   baud_q;
  logic                tx_q;
  logic                fifo_r_q;
  logic                busy_q;
  logic                done_q;

  logic [BAUD_W-1:0]   baud_d;
  logic [BIT_W-1:0]    bit_d;
  logic                baud_wrap;

  assign baud_d    = baud_q + 1'b1;
  assign bit_d     = bit_q + 1'b1;
  assign baud_wrap = (baud_q == BAUD_LAST);

  assign fifo_r    = fifo_r_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign byte_done = done_q;

  // Frame sequencer: state, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
      tx_q     <= 1'b1;
      fifo_r_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      fifo_r_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          tx_q   <= 1'b1;
          if (enable && !fifo_is_empty) begin
            state_q  <= POP;
            fifo_r_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        POP: begin
          // read data appears on fifo_dout during the following cycle
          state_q <= LOAD;
        end
        LOAD: begin
          shift_q <= fifo_dout;
          baud_q  <= '0;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_d;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == BIT_LAST) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_d;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_d;
          end
        end
        STOP: begin
          if (baud_q == BAUD_PRE) begin
            done_q <= 1'b1;
          end
          if (baud_wrap) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_d;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed/randomized bench for fifo_serial_tx with a FIFO model, a line
// decoder and a cycle-level frame reference derived from the frame format.
module tb_fifo_serial_tx;

  localparam int CPB  = 4;
  localparam int DW   = 8;
  localparam int FLEN = 3 + (DW + 2) * CPB;   // 43 cycles per byte

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_is_empty;
  logic          fifo_r;
  logic [DW-1:0] fifo_dout = '0;
  logic          tx;
  logic          busy;
  logic          byte_done;

  int tests = 0;
  int fails = 0;

  fifo_serial_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .fifo_is_empty (fifo_is_empty),
    .fifo_r        (fifo_r),
    .fifo_dout     (fifo_dout),
    .tx            (tx),
    .busy          (busy),
    .byte_done     (byte_done)
  );

  always #5 clk = ~clk;

  // FIFO model: written by the stimulus, read by the DUT strobe
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int bad_pops = 0;
  assign fifo_is_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_r === 1'b1) begin
      if (wr_ptr == rd_ptr) bad_pops <= bad_pops + 1;
      fifo_dout <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
      pops      <= pops + 1;
    end
  end

  // Line decoder: samples each bit at its centre, records {stop, data}
  int           rx_cnt = -1;
  logic [DW-1:0] rx_sh = '0;
  logic [DW:0]  rx_q [$];

  always @(negedge clk) begin
    if (!reset) begin
      rx_cnt <= -1;
    end else if (rx_cnt < 0) begin
      if (tx === 1'b0) rx_cnt <= 0;
    end else begin
      if (rx_cnt >= 5 && rx_cnt <= 5 + 4 * (DW - 1) && ((rx_cnt - 5) % CPB) == 0)
        rx_sh[(rx_cnt - 5) / CPB] <= tx;
      if (rx_cnt == 5 + CPB * DW) begin
        rx_q.push_back({tx, rx_sh});
        rx_cnt <= -1;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check_rx(input logic [DW-1:0] b);
    chk("rx_count", (rx_q.size() > 0) ? 1 : 0, 1);
    if (rx_q.size() > 0) chk("rx_byte", {23'd0, rx_q.pop_front()}, {23'd0, 1'b1, b});
  endtask

  // Waits (bounded) for the pop strobe, then checks every cycle of the frame
  // against the line levels implied by the byte value.
  task automatic check_frame(input logic [DW-1:0] d, input int drop_at,
                             input int abort_at, output int waited);
    logic exp_tx;
    int   idx;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (fifo_r !== 1'b1 && waited < 300);
    chk("pop_seen", {31'd0, fifo_r}, 1);
    if (fifo_r !== 1'b1) return;
    for (int k = 0; k < FLEN; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 2) exp_tx = 1'b1;
      else begin
        idx = (k - 2) / CPB;
        if (idx == 0) exp_tx = 1'b0;
        else if (idx <= DW) exp_tx = d[idx - 1];
        else exp_tx = 1'b1;
      end
      chk("frame_tx",   {31'd0, tx},        {31'd0, exp_tx});
      chk("frame_busy", {31'd0, busy},      (k <= FLEN - 2) ? 1 : 0);
      chk("frame_pop",  {31'd0, fifo_r},    (k == 0) ? 1 : 0);
      chk("frame_done", {31'd0, byte_done}, (k == FLEN - 2) ? 1 : 0);
      if (k == drop_at) enable = 1'b0;
      if (k == abort_at) begin
        #2 reset = 1'b0;
        #1;
        chk("async_rst_tx",   {31'd0, tx},        1);
        chk("async_rst_busy", {31'd0, busy},      0);
        chk("async_rst_pop",  {31'd0, fifo_r},    0);
        chk("async_rst_done", {31'd0, byte_done}, 0);
        return;
      end
    end
  endtask

  initial begin
    int w;
    logic [DW-1:0] rb [0:2];
    logic [DW-1:0] x, y;
    logic [DW-1:0] seq4 [0:3];
    seq4[0] = 8'd26; seq4[1] = 8'd33; seq4[2] = 8'd45; seq4[3] = 8'd112;

    // Reset held with data present and enable high
    push(8'd26);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_tx",   {31'd0, tx},        1);
      chk("rst_pop",  {31'd0, fifo_r},    0);
      chk("rst_busy", {31'd0, busy},      0);
      chk("rst_done", {31'd0, byte_done}, 0);
    end
    reset = 1'b1;

    // Single byte 0x1A
    check_frame(8'd26, -1, -1, w);
    chk("first_pop_latency", w, 1);
    check_rx(8'd26);

    // Four back-to-back bytes
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(seq4[i]);
    for (int i = 0; i < 4; i++) begin
      check_frame(seq4[i], -1, -1, w);
      chk("b2b_spacing", w, 1);
    end
    for (int i = 0; i < 4; i++) check_rx(seq4[i]);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("no_extra_pop", {31'd0, fifo_r}, 0);
    end
    chk("pops_after_four", pops, 5);

    // Empty FIFO with enable high, then data present with enable low
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("empty_idle_pop", {31'd0, fifo_r}, 0);
      chk("empty_idle_tx",  {31'd0, tx},     1);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rb[i] = 8'($urandom_range(0, 255));
      push(rb[i]);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk("disabled_pop", {31'd0, fifo_r}, 0);
      chk("disabled_tx",  {31'd0, tx},     1);
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_frame(rb[i], -1, -1, w);
      chk("enable_latency", w, 1);
    end
    for (int i = 0; i < 3; i++) check_rx(rb[i]);

    // Enable dropped during the data bits of 233
    @(negedge clk);
    enable = 1'b0;
    x = 8'($urandom_range(0, 255));
    push(8'd233);
    push(x);
    @(negedge clk);
    enable = 1'b1;
    check_frame(8'd233, 15, -1, w);
    check_rx(8'd233);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("after_drop_pop", {31'd0, fifo_r}, 0);
    end
    chk("fifo_level_after_drop", wr_ptr - rd_ptr, 1);

    // Asynchronous reset during data bit 3 of byte x
    y = 8'($urandom_range(0, 255));
    push(y);
    enable = 1'b1;
    check_frame(x, -1, 2 + CPB * 4 + 1, w);
    @(negedge clk);
    chk("rst_hold_busy", {31'd0, busy}, 0);
    chk("rst_hold_tx",   {31'd0, tx},   1);
    @(negedge clk);
    reset = 1'b1;
    check_frame(y, -1, -1, w);
    chk("post_rst_latency", w, 1);
    check_rx(y);
    chk("rx_queue_drained", rx_q.size(), 0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("final_idle_pop", {31'd0, fifo_r}, 0);
    end
    chk("total_pops", pops, wr_ptr);
    chk("pop_while_empty", bad_pops, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
Read-side drain engine for the hub's byte FIFO. It pops bytes from the FIFO read port whenever the FIFO is non-empty and transmission is enabled. Each byte is serialized onto a single asynchronous line as a 1-start/8-data/1-stop frame, LSB first. It sits between a port FIFO and the physical output pin of a hub port.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit period; legal range is 2 or more.
DATA_W, 8, FIFO word and frame data width.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
enable  input  1  permits starting a new frame; sampled only in IDLE.
fifo_is_empty  input  1  FIFO empty flag.
fifo_r  output  1  FIFO read strobe; one-cycle pulse per byte.
fifo_dout  input  DATA_W  FIFO read data; valid the cycle after fifo_r is sampled high.
tx  output  1  serial line, idle high.
busy  output  1  high whenever state is not IDLE.
byte_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; tx=1; fifo_r=0; busy=0; byte_done=0.
  - Shift register, bit counter and baud counter all 0.
  - Takes effect immediately, including mid-frame; tx returns to 1 with no partial-frame completion.
- All outputs are registered. Encoding: fifo_r = (state==POP); busy = (state!=IDLE).
- States and transitions:
  - IDLE: tx=1. If enable=1 and fifo_is_empty=0, go to POP; otherwise stay.
  - POP: one cycle; fifo_r=1; tx=1. Go to LOAD.
  - LOAD: one cycle; capture fifo_dout into the shift register; tx=1. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles. Go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit period. After DATA_W bits, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. byte_done=1 on the final cycle. Go to IDLE.
- Timing:
  - Per-byte period is 3 + (DATA_W+2)*CLKS_PER_BIT cycles (IDLE, POP, LOAD, then the frame).
  - Back-to-back bytes: the start bit of the next frame begins 3 cycles after the previous stop bit ends.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Bit counter width is clog2(DATA_W)+1.
- Boundary conditions:
  - fifo_r is never asserted while fifo_is_empty=1 at the IDLE decision cycle. Exactly one pop occurs per frame.
  - fifo_is_empty and enable are ignored outside IDLE.
  - enable falling mid-frame lets the current frame complete; no further pop follows.
  - FIFO becoming empty during a frame: the frame completes and the block stays in IDLE.
  - Simultaneous FIFO write and this block's read are the FIFO's concern; this block only issues single-cycle reads.
  - Release of reset mid-line: the first frame can start no earlier than 1 cycle after reset deasserts (IDLE decision cycle).

Test Plan:
- Reset check (CLKS_PER_BIT=4): hold reset=0 for 100 ns with the FIFO model holding data -> tx=1, fifo_r=0, busy=0, byte_done=0 throughout.
- Single byte 26 (0x1A), enable=1 -> one fifo_r pulse, then tx sequence 0 | 0,1,0,1,1,0,0,0 | 1, each level 4 cycles. One byte_done pulse at frame end; busy high for 42 cycles.
- Four bytes 26, 33, 45, 112 preloaded -> exactly 4 fifo_r pulses spaced 43 cycles apart. Decoded bytes arrive in order 26, 33, 45, 112. Busy drops after the 4th stop bit; no 5th pop.
- Empty FIFO or enable=0 with data present for 500 cycles -> fifo_r stays 0 and tx stays 1. Raising enable later starts the frame on the following decision cycle.
- enable dropped during the data bits of byte 233 -> byte 233 completes correctly with byte_done pulsed, and no subsequent pop despite the non-empty FIFO.
- reset pulsed low during bit 3 of a frame -> tx=1 and busy=0 immediately (asynchronous). After release, the next byte pops and transmits cleanly; the interrupted byte is not retransmitted.
